// File: rtl/brptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : brptr_sync
// Brief    : Read-side pointer, empty/almost-empty flags and fill level for a
//            dual-clock FIFO. The write pointer is synchronised and filtered.
// Revision : 1.0
// ============================================================================
module brptr_sync #(
   parameter int SIZE      = 4,
   parameter int AEMPTY_TH = 2
) (
   input  logic            rclk,
   input  logic            rst_n,
   input  logic            rinc,
   input  logic [SIZE-1:0] wptr,
   input  logic            wstate,
   output logic [SIZE-1:0] rptr,
   output logic            rstate,
   output logic            empty,
   output logic            aempty,
   output logic [SIZE:0]   rlevel
);

   localparam logic [SIZE:0] AE_TH = (SIZE+1)'(AEMPTY_TH);

   logic [SIZE:0]   rbin;
   logic [SIZE:0]   rbnext;
   logic [SIZE:0]   s1;
   logic [SIZE:0]   s2;
   logic [SIZE:0]   s3;
   logic [SIZE:0]   wq;
   logic [SIZE-1:0] wqb;
   logic [SIZE:0]   wcnt;
   logic [SIZE:0]   level;

   assign rbnext = empty ? rbin : rbin + {{SIZE{1'b0}}, rinc};

   generate
      for (genvar i = 0; i < SIZE; i++) begin : g_g2b
         assign wqb[i] = ^wq[SIZE-1:i];
      end
   endgenerate

   assign wcnt  = {wq[SIZE], wqb};
   assign level = wcnt - rbnext;

   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         rbin   <= '0;
         rptr   <= '0;
         rstate <= 1'b0;
      end else begin
         rbin   <= rbnext;
         rptr   <= rbnext[SIZE-1:0] ^ (rbnext[SIZE-1:0] >> 1);
         rstate <= rbnext[SIZE];
      end
   end

   // wq only takes a sample seen identically on two consecutive edges, which
   // hides the wstate / gray-msb skew at address wrap.
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
         wq <= '0;
      end else begin
         s1 <= {wstate, wptr};
         s2 <= s1;
         s3 <= s2;
         if (s2 == s3)
            wq <= s2;
      end
   end

   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         empty  <= 1'b1;
         aempty <= 1'b1;
         rlevel <= '0;
      end else begin
         empty  <= (wcnt == rbnext);
         rlevel <= level;
         aempty <= (level <= AE_TH);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_brptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_brptr_sync
// Brief    : Randomised and directed bench for brptr_sync with a count-based
//            reference model of the read-side view of the FIFO.
// Revision : 1.0
// ============================================================================
module tb_brptr_sync;

   localparam int SIZE  = 4;
   localparam int AE_TH = 2;

   logic       rclk = 1'b0;
   logic       rst_n;
   logic       rinc;
   logic [3:0] wptr;
   logic       wstate;
   logic [3:0] rptr;
   logic       rstate;
   logic       empty;
   logic       aempty;
   logic [4:0] rlevel;

   int checks   = 0;
   int failures = 0;

   // Model state: absolute counts, visible write count and flags
   int wc;
   int rc;
   int m_wq;
   bit m_empty;
   int m_level;
   int hist[$];

   brptr_sync #(.SIZE(SIZE), .AEMPTY_TH(AE_TH)) dut (
      .rclk   (rclk),
      .rst_n  (rst_n),
      .rinc   (rinc),
      .wptr   (wptr),
      .wstate (wstate),
      .rptr   (rptr),
      .rstate (rstate),
      .empty  (empty),
      .aempty (aempty),
      .rlevel (rlevel)
   );

   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] gray4(input int b);
      int v;
      v = b % 16;
      return 4'((v ^ (v >> 1)) & 15);
   endfunction

   task automatic drive_write();
      wptr   = gray4(wc);
      wstate = ((wc % 32) >= 16);
   endtask

   task automatic model_reset();
      hist    = {0, 0, 0, 0};
      m_wq    = 0;
      rc      = 0;
      m_empty = 1'b1;
      m_level = 0;
   endtask

   // The reader sees the newest write count that was sampled identically on
   // two consecutive edges, delayed by the synchroniser depth.
   task automatic model_edge(input bit rd, input int wsample);
      int diff;
      int last;
      if (rd && !m_empty) rc++;
      diff    = ((m_wq - (rc % 32)) + 32) % 32;
      m_empty = (diff == 0);
      m_level = diff;
      hist.push_back(wsample % 32);
      last = hist.size() - 1;
      if (hist[last-2] == hist[last-3]) m_wq = hist[last-2];
      if (hist.size() > 8) void'(hist.pop_front());
   endtask

   task automatic check_outputs();
      check_eq("rptr",   rptr,   gray4(rc));
      check_eq("rstate", rstate, ((rc % 32) >= 16));
      check_eq("empty",  empty,  m_empty);
      check_eq("rlevel", rlevel, m_level);
      check_eq("aempty", aempty, (m_level <= AE_TH));
   endtask

   task automatic step(input bit rd);
      rinc = rd;
      drive_write();
      @(posedge rclk);
      model_edge(rd, wc);
      #1;
      check_outputs();
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_rptr"},   rptr,   0);
      check_eq({tag, "_rstate"}, rstate, 0);
      check_eq({tag, "_empty"},  empty,  1);
      check_eq({tag, "_aempty"}, aempty, 1);
      check_eq({tag, "_rlevel"}, rlevel, 0);
   endtask

   // Called between edges; holds reset across a few edges with noisy inputs
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_async");
      for (int i = 0; i < 3; i++) begin
         rinc   = 1'($urandom);
         wptr   = 4'($urandom);
         wstate = 1'($urandom);
         @(posedge rclk);
         #1;
         check_reset_values("rst_hold");
      end
      wc   = 0;
      rinc = 1'b0;
      drive_write();
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic scen_three_writes();
      for (int i = 1; i <= 3; i++) begin
         wc = i;
         step(1'b0);
      end
      for (int i = 0; i < 6; i++) step(1'b0);
      check_eq("s2_empty",  empty,  0);
      check_eq("s2_rlevel", rlevel, 3);
      check_eq("s2_aempty", aempty, 0);
      step(1'b1);
      check_eq("s2_rd1_rptr", rptr, 4'b0001);
      check_eq("s2_rd1_lvl",  rlevel, 2);
      step(1'b1);
      check_eq("s2_rd2_rptr", rptr, 4'b0011);
      check_eq("s2_rd2_lvl",  rlevel, 1);
      step(1'b1);
      check_eq("s2_rd3_rptr",  rptr, 4'b0010);
      check_eq("s2_rd3_lvl",   rlevel, 0);
      check_eq("s2_rd3_empty", empty, 1);
   endtask

   initial begin
      rst_n  = 1'b1;
      rinc   = 1'b0;
      wc     = 0;
      drive_write();
      model_reset();
      #2;
      apply_reset();

      scen_three_writes();

      // Reads while empty are ignored
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         check_eq("s3_rptr",   rptr,   4'b0010);
         check_eq("s3_rlevel", rlevel, 0);
         check_eq("s3_rstate", rstate, 0);
      end

      // Full-depth wrap, twice
      apply_reset();
      for (int i = 1; i <= 16; i++) begin
         wc = i;
         step(1'b0);
      end
      for (int i = 0; i < 6; i++) step(1'b0);
      check_eq("s4_full_lvl",   rlevel, 16);
      check_eq("s4_full_empty", empty,  0);
      for (int i = 0; i < 16; i++) step(1'b1);
      check_eq("s4_wrap_rptr",   rptr,   0);
      check_eq("s4_wrap_rstate", rstate, 1);
      check_eq("s4_wrap_empty",  empty,  1);
      for (int i = 17; i <= 32; i++) begin
         wc = i;
         step(1'b0);
      end
      for (int i = 0; i < 6; i++) step(1'b0);
      for (int i = 0; i < 16; i++) step(1'b1);
      check_eq("s4_wrap2_rptr",   rptr,   0);
      check_eq("s4_wrap2_rstate", rstate, 0);
      check_eq("s4_wrap2_empty",  empty,  1);

      // Unstable write pointer is not absorbed
      apply_reset();
      wc = 1;
      for (int i = 0; i < 6; i++) step(1'b0);
      check_eq("s5_pre_lvl", rlevel, 1);
      for (int i = 0; i < 8; i++) begin
         wc = (i % 2 == 0) ? 2 : 1;
         step(1'b0);
         check_eq("s5_tgl_lvl",   rlevel, 1);
         check_eq("s5_tgl_empty", empty,  0);
      end
      wc = 2;
      for (int i = 0; i < 6; i++) step(1'b0);
      check_eq("s5_post_lvl", rlevel, 2);

      // Asynchronous reset in the middle of operation
      apply_reset();
      for (int i = 1; i <= 5; i++) begin
         wc = i;
         step(1'b0);
      end
      for (int i = 0; i < 6; i++) step(1'b0);
      check_eq("s6_pre_lvl", rlevel, 5);
      #2;
      apply_reset();
      scen_three_writes();

      // Random traffic, writer never more than a full FIFO ahead
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         if (($urandom % 3 == 0) && (wc - rc < 16)) wc++;
         step(1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
